// File: rtl/uart_io_pkg.sv
// Shared definitions for the UART output transmitter: FSM encodings and frame sizing.
// Frame length depends on UART_TX_PARITY_EN (8E1 when defined, 8N1 otherwise).
package uart_io_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   localparam int DEFAULT_CLK_DIV = 434;
   localparam int DATA_BITS       = 8;

`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/uart_io_if.sv
// Byte hand-off from the I/O output block into the UART transmitter queue.
interface uart_io_if;

   logic [7:0] uart_io_char;
   logic       uart_io_we;
   logic       uart_io_full;

   modport master (
      output uart_io_char,
      output uart_io_we,
      input  uart_io_full
   );

   modport slave (
      input  uart_io_char,
      input  uart_io_we,
      output uart_io_full
   );

endinterface

// File: rtl/uart_io_fifo.sv
// Synchronous FIFO with extra-bit pointers; full/empty decode only from registers.
// Pushes while full are dropped and latch a sticky overrun flag.
module uart_io_fifo #(
   parameter int DATA_W  = 8,
   parameter int FIFO_AW = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              full,
   output logic              empty,
   output logic [FIFO_AW:0]  count,
   output logic              overrun
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

   logic [DATA_W-1:0] mem [DEPTH];
   logic [FIFO_AW:0]  wp;
   logic [FIFO_AW:0]  rp;
   logic              push_ok;
   logic              pop_ok;

   assign count    = wp - rp;
   assign full     = (count == FULL_CNT);
   assign empty    = (wp == rp);
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign pop_data = mem[rp[FIFO_AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp      <= '0;
         rp      <= '0;
         overrun <= 1'b0;
      end else begin
         if (push_ok)
            wp <= wp + 1'b1;
         if (pop_ok)
            rp <= rp + 1'b1;
         // full is registered state, so a same-cycle pop never rescues the push
         if (push && full)
            overrun <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wp[FIFO_AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/uart_io_tx.sv
// Queued 8N1 serial transmitter for the memory-mapped UART output port.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_io_tx
   import uart_io_pkg::*;
#(
   parameter int CLK_DIV = DEFAULT_CLK_DIV,
   parameter int FIFO_AW = 4
) (
   input  logic     clk,
   input  logic     rst,
   uart_io_if.slave io,
   output logic     tx,
   output logic     tx_busy,
   output logic     tx_fifo_overrun
);

   localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);

   tx_state_t            state;
   tx_state_t            state_next;
   logic [15:0]          baud;
   logic [15:0]          baud_next;
   logic [2:0]           bit_idx;
   logic [2:0]           bit_idx_next;
   logic [DATA_BITS-1:0] shreg;
   logic                 tx_next;
   logic                 baud_done;

   logic                 fifo_pop;
   logic [DATA_BITS-1:0] fifo_data;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [FIFO_AW:0]     fifo_count;

   uart_io_fifo #(
      .DATA_W  (DATA_BITS),
      .FIFO_AW (FIFO_AW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (io.uart_io_we),
      .push_data (io.uart_io_char),
      .pop       (fifo_pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .overrun   (tx_fifo_overrun)
   );

   assign io.uart_io_full = fifo_full;
   assign baud_done       = (baud == '0);

   always_comb begin
      state_next   = state;
      baud_next    = baud;
      bit_idx_next = bit_idx;
      fifo_pop     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               state_next = ST_START;
               baud_next  = BAUD_RELOAD;
            end
         end
         ST_START: begin
            if (baud_done) begin
               state_next   = ST_DATA;
               bit_idx_next = 3'd0;
               baud_next    = BAUD_RELOAD;
            end else begin
               baud_next = baud - 16'd1;
            end
         end
         ST_DATA: begin
            if (baud_done) begin
               baud_next = BAUD_RELOAD;
               if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_next = ST_PARITY;
`else
                  state_next = ST_STOP;
`endif
               end else begin
                  bit_idx_next = bit_idx + 3'd1;
               end
            end else begin
               baud_next = baud - 16'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (baud_done) begin
               state_next = ST_STOP;
               baud_next  = BAUD_RELOAD;
            end else begin
               baud_next = baud - 16'd1;
            end
         end
`endif
         ST_STOP: begin
            if (baud_done)
               state_next = ST_IDLE;
            else
               baud_next = baud - 16'd1;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // tx is decoded from the next state so the registered line lines up with state
   always_comb begin
      tx_next = 1'b1;
      case (state_next)
         ST_START:  tx_next = 1'b0;
         ST_DATA:   tx_next = shreg[bit_idx_next];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: tx_next = even_parity(shreg);
`endif
         default:   tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         baud    <= '0;
         bit_idx <= '0;
         tx      <= 1'b1;
         tx_busy <= 1'b0;
      end else begin
         state   <= state_next;
         baud    <= baud_next;
         bit_idx <= bit_idx_next;
         tx      <= tx_next;
         tx_busy <= (state != ST_IDLE) || (fifo_count != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_pop)
         shreg <= fifo_data;
   end

endmodule
